mem_access_ctrl: RTL and testbench

//  MEM-stage sequencer for the EX/MEM -> MEM/WB path of the 5-stage pipeline.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 tb/tb_mem_access_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage access path: funct3 encodings and sequencer state.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, BUSY} mac_state_t;

  // funct3[1:0] encodes size: 00 byte, 01 half, 1x word
  function automatic logic misalign(input logic [1:0] sz, input logic [1:0] off);
    return sz[1] ? (off != 2'b00) : (sz[0] & off[0]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load lane select + extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misal
);

  logic [1:0]  sz;
  logic [31:0] sh;

  assign sz    = funct3[1:0];
  assign misal = misalign(sz, off);

  always_comb begin
    be = 4'b1111;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata[VEC_W*i +: VEC_W] =
      (sz == 2'b00) ? wd[7:0] :
      (sz == 2'b01) ? wd[VEC_W*(i%2) +: VEC_W] :
                      wd[VEC_W*i +: VEC_W];
  end

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = rdata;
    case (funct3)
      F3_LB:   rdata_ext = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  rdata_ext = {24'b0, sh[7:0]};
      F3_LH:   rdata_ext = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  rdata_ext = {16'b0, sh[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ready handshake per load/store, stalls the pipe while
// memory is busy, and turns misaligned or timed-out accesses into a WB bubble.
module mem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        flushW,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  mac_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access, is_load, abort;
  logic [3:0]       be;
  logic [31:0]      wdata, rdata_ext;
  logic             misal;

  lsu_align u_align (
    .funct3    (funct3M),
    .off       (aluresultM[1:0]),
    .wd        (writedataM),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata     (wdata),
    .rdata_ext (rdata_ext),
    .misal     (misal)
  );

  // A new access is never started in a reset cycle
  assign access  = (memreadM | memwriteM) & reset;
  assign is_load = memreadM & ~memwriteM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    flushW     = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misal) begin
            misaligned = 1'b1;
            flushW     = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (!mem_ready) begin
              state_d = BUSY;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO) begin
          mem_req = 1'b0;
          abort   = 1'b1;
          bus_err = 1'b1;
          flushW  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stallM    = mem_req & ~mem_ready & ~abort;
  // Bus side idles at zero whenever no request is outstanding
  assign mem_we    = mem_req & memwriteM;
  assign mem_addr  = mem_req ? {aluresultM[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = mem_we ? wdata : 32'h0;
  assign readdataM = (mem_req & mem_ready & is_load) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized checks of mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM, writedataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata, readdataM;
  logic        stallM, flushW, misaligned, bus_err;

  int tests = 0;
  int fails = 0;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
    .funct3M(funct3M), .aluresultM(aluresultM), .writedataM(writedataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .readdataM(readdataM), .stallM(stallM), .flushW(flushW),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {mem_req, stallM, flushW, misaligned, bus_err}
  function automatic logic [31:0] flags();
    return {27'b0, mem_req, stallM, flushW, misaligned, bus_err};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [1:0] o);
    int m = ((1 << nbytes(f3)) - 1) << o;
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    longint v;
    int nb = nbytes(f3);
    if (nb == 4) return w;
    v = longint'((w >> (8 * o)) & ((32'h1 << (8 * nb)) - 1));
    if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    memreadM = 0; memwriteM = 0; funct3M = 0; aluresultM = 0; writedataM = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  // One instruction in MEM; lat = cycles before mem_ready (lat > TO never completes)
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rv);
    logic ld = rd & ~wr;
    int   nb = nbytes(f3);
    memreadM = rd; memwriteM = wr; funct3M = f3; aluresultM = a; writedataM = wd;
    mem_ready = 0;
    if ((a % nb) != 0) begin
      #2;
      chk({tag, ":misal_flags"}, flags(), 32'b00110);
      chk({tag, ":misal_rd"}, readdataM, 32'h0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c < 1000; c++) begin
        mem_ready = (c == lat);
        mem_rdata = (c == lat) ? rv : $urandom;
        #2;
        if (c == lat) begin
          chk({tag, ":done_flags"}, flags(), 32'b10000);
          chk({tag, ":addr"}, mem_addr, {a[31:2], 2'b00});
          chk({tag, ":be"}, {28'b0, mem_be}, exp_be(f3, a[1:0]));
          chk({tag, ":we"}, {31'b0, mem_we}, {31'b0, wr});
          chk({tag, ":wdata"}, mem_wdata, wr ? exp_wdata(f3, wd) : 32'h0);
          chk({tag, ":rdata"}, readdataM, ld ? exp_load(f3, a[1:0], rv) : 32'h0);
          @(posedge clk); #1;
          break;
        end else if (c == TO) begin
          chk({tag, ":abort_flags"}, flags(), 32'b00101);
          chk({tag, ":abort_rd"}, readdataM, 32'h0);
          @(posedge clk); #1;
          break;
        end else begin
          chk({tag, ":wait_flags"}, flags(), 32'b11000);
          chk({tag, ":wait_addr"}, mem_addr, {a[31:2], 2'b00});
          chk({tag, ":wait_be"}, {28'b0, mem_be}, exp_be(f3, a[1:0]));
          @(posedge clk); #1;
        end
      end
    end
    idle_inputs();
    #2;
    chk({tag, ":after_idle"}, flags(), 32'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] ldf[5];
    logic [2:0] stf[3];
    ldf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    stf = '{3'b000, 3'b001, 3'b010};

    // reset state
    idle_inputs();
    reset = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_flags", flags(), 32'b0);
    chk("reset_bus", {mem_addr}, 32'h0);
    chk("reset_rd", readdataM, 32'h0);
    reset = 1;
    @(posedge clk); #1;

    // 1: zero-wait LW
    run_txn("lw0", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    // 2: LB / LBU with three wait cycles
    run_txn("lb3", 1, 0, 3'b000, 32'h103, 32'h0, 3, 32'h80123456);
    chk("lb_model", exp_load(3'b000, 2'd3, 32'h80123456), 32'hFFFFFF80);
    run_txn("lbu3", 1, 0, 3'b100, 32'h103, 32'h0, 3, 32'h80123456);
    // 3: SH to upper half
    run_txn("sh", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 1, 32'h0);
    // 4: misaligned LW
    run_txn("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    // 5: timeout
    run_txn("tmo", 1, 0, 3'b010, 32'h40, 32'h0, 100, 32'h0);
    // both read and write: the store wins
    run_txn("rdwr", 1, 1, 3'b010, 32'h80, 32'hCAFEF00D, 0, 32'h12345678);

    // 6: reset during BUSY
    memreadM = 1; funct3M = 3'b010; aluresultM = 32'h200; mem_ready = 0;
    #2;
    chk("rst_busy_c0", flags(), 32'b11000);
    @(posedge clk); #1;
    #2;
    chk("rst_busy_c1", flags(), 32'b11000);
    reset = 0;
    idle_inputs();
    @(posedge clk); #1;
    #2;
    chk("rst_after", flags(), 32'b0);
    reset = 1;
    @(posedge clk); #1;
    run_txn("lw_post_rst", 1, 0, 3'b010, 32'h300, 32'h0, 2, 32'hA5A55A5A);

    // randomized transactions
    for (int n = 0; n < 150; n++) begin
      logic        wr, rd;
      logic [2:0]  f3;
      logic [31:0] a;
      int          lat;
      wr  = ($urandom_range(0, 2) == 0);
      rd  = !wr || ($urandom_range(0, 7) == 0);
      f3  = wr ? stf[$urandom_range(0, 2)] : ldf[$urandom_range(0, 4)];
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 5);
      run_txn("rnd", rd, wr, f3, a, $urandom, lat, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
